// File: rtl/ts_pkg.sv
// Shared constants and state encoding for the TS sync locker.
package ts_pkg;

  localparam int unsigned TS_PACK_BYTE_SIZE = 188;
  localparam logic [7:0] TS_SYNC_BYTE = 8'h47;

  typedef enum logic [1:0] {
    HUNT   = 2'd0,
    VERIFY = 2'd1,
    LOCKED = 2'd2
  } ts_state_e;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter; a clear wins over a same-cycle increment.
module sat_counter #(
  parameter int unsigned CNT_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 inc,
  input  logic                 clr,
  output logic [CNT_WIDTH-1:0] count
);

  logic [CNT_WIDTH-1:0] count_q;
  logic [CNT_WIDTH-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (inc && !(&count_q)) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/ts_sync_locker.sv
// Finds 0x47 packet alignment on a raw TS byte stream and forwards
// only whole, aligned packets with a first-byte sync pulse.
module ts_sync_locker
  import ts_pkg::*;
#(
  parameter int unsigned PACK_BYTE_SIZE = TS_PACK_BYTE_SIZE,
  parameter logic [7:0]  SYNC_BYTE      = TS_SYNC_BYTE,
  parameter int unsigned LOCK_COUNT     = 3,
  parameter int unsigned UNLOCK_COUNT   = 3,
  parameter int unsigned CNT_WIDTH      = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 enable,
  input  logic                 clear_counters,
  input  logic [7:0]           in_data,
  input  logic                 in_valid,
  output logic [7:0]           out_data,
  output logic                 out_valid,
  output logic                 out_sync,
  output logic                 locked,
  output logic [CNT_WIDTH-1:0] packet_count,
  output logic [CNT_WIDTH-1:0] drop_count
);

  localparam logic [7:0] LAST_BYTE = 8'(PACK_BYTE_SIZE - 1);
  localparam logic [7:0] LOCK_N    = 8'(LOCK_COUNT);
  localparam logic [7:0] UNLOCK_N  = 8'(UNLOCK_COUNT);

  ts_state_e  state_q, state_d;
  logic [7:0] byte_cnt_q, byte_cnt_d;
  logic [7:0] good_cnt_q, good_cnt_d;
  logic [7:0] miss_cnt_q, miss_cnt_d;
  logic       drop_pkt_q, drop_pkt_d;
  logic [7:0] out_data_q, out_data_d;
  logic       out_valid_q, out_valid_d;
  logic       out_sync_q, out_sync_d;
  logic       locked_q, locked_d;
  logic       pkt_inc;
  logic       drop_inc;

  logic       boundary;
  logic       is_sync;
  logic [7:0] cnt_nxt;

  assign boundary = (byte_cnt_q == 8'd0);
  assign is_sync  = (in_data == SYNC_BYTE);
  assign cnt_nxt  = (byte_cnt_q == LAST_BYTE) ? 8'd0 : byte_cnt_q + 8'd1;

  always_comb begin
    state_d     = state_q;
    byte_cnt_d  = byte_cnt_q;
    good_cnt_d  = good_cnt_q;
    miss_cnt_d  = miss_cnt_q;
    drop_pkt_d  = drop_pkt_q;
    out_data_d  = in_data;
    out_valid_d = 1'b0;
    out_sync_d  = 1'b0;
    pkt_inc     = 1'b0;
    drop_inc    = 1'b0;
    if (!enable) begin
      state_d    = HUNT;
      byte_cnt_d = 8'd0;
      good_cnt_d = 8'd0;
      miss_cnt_d = 8'd0;
      drop_pkt_d = 1'b0;
    end else if (in_valid) begin
      unique case (state_q)
        HUNT: begin
          if (is_sync) begin
            state_d    = VERIFY;
            byte_cnt_d = 8'd1;
            good_cnt_d = 8'd1;
          end
        end
        VERIFY: begin
          byte_cnt_d = cnt_nxt;
          if (boundary && is_sync) begin
            good_cnt_d = good_cnt_q + 8'd1;
            if (good_cnt_q + 8'd1 >= LOCK_N) begin
              state_d     = LOCKED;
              miss_cnt_d  = 8'd0;
              drop_pkt_d  = 1'b0;
              out_valid_d = 1'b1;
              out_sync_d  = 1'b1;
              pkt_inc     = 1'b1;
            end
          end else if (boundary) begin
            // Misplaced sync: the candidate alignment was false.
            state_d    = HUNT;
            byte_cnt_d = 8'd0;
            good_cnt_d = 8'd0;
          end
        end
        LOCKED: begin
          byte_cnt_d = cnt_nxt;
          if (boundary && is_sync) begin
            miss_cnt_d  = 8'd0;
            drop_pkt_d  = 1'b0;
            out_valid_d = 1'b1;
            out_sync_d  = 1'b1;
            pkt_inc     = 1'b1;
          end else if (boundary) begin
            miss_cnt_d = miss_cnt_q + 8'd1;
            drop_pkt_d = 1'b1;
            drop_inc   = 1'b1;
            if (miss_cnt_q + 8'd1 >= UNLOCK_N) begin
              state_d    = HUNT;
              byte_cnt_d = 8'd0;
              good_cnt_d = 8'd0;
              miss_cnt_d = 8'd0;
              drop_pkt_d = 1'b0;
            end
          end else begin
            out_valid_d = !drop_pkt_q;
          end
        end
        default: begin
          state_d = HUNT;
        end
      endcase
    end
    locked_d = (state_d == LOCKED);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= HUNT;
      byte_cnt_q  <= 8'd0;
      good_cnt_q  <= 8'd0;
      miss_cnt_q  <= 8'd0;
      drop_pkt_q  <= 1'b0;
      out_data_q  <= 8'd0;
      out_valid_q <= 1'b0;
      out_sync_q  <= 1'b0;
      locked_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      byte_cnt_q  <= byte_cnt_d;
      good_cnt_q  <= good_cnt_d;
      miss_cnt_q  <= miss_cnt_d;
      drop_pkt_q  <= drop_pkt_d;
      out_data_q  <= out_valid_d ? out_data_d : 8'd0;
      out_valid_q <= out_valid_d;
      out_sync_q  <= out_sync_d;
      locked_q    <= locked_d;
    end
  end

  sat_counter #(.CNT_WIDTH(CNT_WIDTH)) u_pkt_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (pkt_inc),
    .clr   (clear_counters),
    .count (packet_count)
  );

  sat_counter #(.CNT_WIDTH(CNT_WIDTH)) u_drop_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (drop_inc),
    .clr   (clear_counters),
    .count (drop_count)
  );

  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign out_sync  = out_sync_q;
  assign locked    = locked_q;

endmodule

// File: doc/ts_sync_locker.md
Name: ts_sync_locker

Overview:
- Sits directly upstream of the TS replacer/monitor RAM block, on the raw MPEG byte input.
- Hunts for 0x47 sync bytes at PACK_BYTE_SIZE spacing, confirms lock, then forwards only packet-aligned bytes with a first-byte sync pulse.
- Downstream filters therefore only ever see whole, aligned packets.
- Drops packets with a missing sync byte; exposes lock status and saturating packet/drop counters for software.

Parameters:
PACK_BYTE_SIZE, 188, bytes per packet; legal range 2..255.
SYNC_BYTE, 8'h47, packet sync byte value.
LOCK_COUNT, 3, consecutive correctly spaced sync bytes needed to lock; minimum 2.
UNLOCK_COUNT, 3, consecutive missed sync bytes that drop lock; minimum 1.
CNT_WIDTH, 32, width of the status counters.

Ports:
clk  in  1  single clock (the byte clock of the TS input).
rst_n  in  1  asynchronous, active-low reset.
enable  in  1  0 forces HUNT and suppresses output.
clear_counters  in  1  synchronous clear of packet_count and drop_count.
in_data  in  8  raw TS byte.
in_valid  in  1  in_data is valid this cycle.
out_data  out  8  aligned TS byte.
out_valid  out  1  out_data is valid.
out_sync  out  1  high with the first byte (0x47) of each forwarded packet.
locked  out  1  high while in LOCKED.
packet_count  out  CNT_WIDTH  packets forwarded, saturating.
drop_count  out  CNT_WIDTH  packets dropped while locked, saturating.

Behaviour:
- Reset: all outputs 0; state HUNT; byte_cnt, good_cnt, miss_cnt and drop_pkt are 0.
- Latency: registered outputs, exactly 1 clk from in_data/in_valid to out_data/out_valid/out_sync.
- Cycles with in_valid=0 advance nothing; out_valid=0 on the next cycle.
- byte_cnt (8 bit) counts valid bytes within a packet, 0..PACK_BYTE_SIZE-1, and wraps to 0.
- A "boundary" is a valid byte seen when byte_cnt==0.
- HUNT:
  - Valid byte == SYNC_BYTE: go to VERIFY with byte_cnt=1, good_cnt=1.
  - Otherwise stay in HUNT.
  - No output.
- VERIFY, at a boundary:
  - Byte == SYNC_BYTE: good_cnt++.
  - If good_cnt reaches LOCK_COUNT: go to LOCKED. This byte is forwarded with out_sync=1, locked=1 on the same output cycle, and packet_count++.
  - Byte != SYNC_BYTE: go to HUNT. The byte is not re-examined.
  - No output while in VERIFY.
- LOCKED, at a boundary with byte == SYNC_BYTE:
  - Set miss_cnt=0 and drop_pkt=0.
  - Forward the byte with out_sync=1; packet_count++.
- LOCKED, at a boundary with byte != SYNC_BYTE:
  - miss_cnt++, drop_pkt=1, drop_count++.
  - The whole packet (PACK_BYTE_SIZE valid bytes) is suppressed.
  - If miss_cnt reaches UNLOCK_COUNT: go to HUNT and clear locked next output cycle.
- LOCKED, non-boundary bytes: forwarded with out_sync=0 unless drop_pkt=1.
- Counters saturate at all-ones.
  - clear_counters has priority over a same-cycle increment: the result is 0.
- enable=0: next state HUNT with all internal counters cleared; outputs go 0 one cycle later. Status counters are held.
- Asynchronous reset mid-packet: immediate return to reset values. No partial packet is forwarded after reset release; the block must re-lock first.
- A 0x47 inside a payload while in HUNT may cause a false VERIFY. The spacing check must reject it.

Decomposition:
- Shared package ts_pkg holds:
  - PACK_BYTE_SIZE default (188) and SYNC_BYTE (8'h47).
  - The state enum: HUNT=0, VERIFY=1, LOCKED=2.
- One sub-module, sat_counter (CNT_WIDTH, inc, clr, clr-priority), is instantiated twice for packet_count and drop_count.

Test Plan:
1. Clean acquisition: 5 back-to-back good packets after reset.
   - out_valid first rises 1 clk after the first byte of packet 3, with out_sync=1, out_data=0x47, locked=1.
   - 3*188 bytes forwarded; packet_count=3.
2. Single corrupt sync while locked: packet 4 first byte = 0x00.
   - No out_valid for those 188 bytes; drop_count=1; locked stays 1.
   - Packet 5 is forwarded; packet_count increments.
3. Loss of lock: 3 consecutive packets with sync 0xB8.
   - drop_count=3; locked=0 after the third boundary; no output until 3 new good packets.
4. False sync: HUNT sees 0x47 at offset 50 of a packet whose real sync is at offset 0.
   - VERIFY fails at offset 50+188 and returns to HUNT.
   - Lock is later achieved on the real boundary; packet_count counts only aligned packets.
5. Gapped input while locked: in_valid toggling 1/0.
   - Output bytes match input order; out_sync only on 0x47 at each 188th valid byte; no counter slip.
6. Reset and enable control:
   - rst_n low at byte 90 of a locked packet: all outputs 0 immediately; after release, a full re-acquisition is needed (as in test 1).
   - enable=0 for 1 cycle: same re-acquisition is needed, but counters are retained.
   - clear_counters together with an increment yields 0.
